// File: rtl/operand_gen_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_gen_pipe_pkg
// Description : Operand source encodings and link-address offset shared by
//               the operand generator and its forwarding muxes.
// Revision    : 1.0 - initial release
// ============================================================================
package operand_gen_pipe_pkg;

    typedef enum logic [1:0] {
        OPG_SRC1_ZERO = 2'd0,
        OPG_SRC1_REG  = 2'd1,
        OPG_SRC1_LINK = 2'd2,
        OPG_SRC1_CP0  = 2'd3
    } opg_src1_e;

    typedef enum logic [2:0] {
        OPG_SRC2_ZERO = 3'd0,
        OPG_SRC2_REG  = 3'd1,
        OPG_SRC2_SEXT = 3'd2,
        OPG_SRC2_ZEXT = 3'd3,
        OPG_SRC2_HI   = 3'd4
    } opg_src2_e;

    localparam int LINK_OFFSET = 8;

endpackage
`default_nettype wire

// File: rtl/operand_gen_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : operand_gen_pipe_if
// Description : Decode-side inputs, forwarding channels and EX-side output
//               handshake of the operand generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface operand_gen_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int RAW     = 5,
    parameter int NUM_FWD = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      flush;
    logic [ADDR_W-1:0]         pc;
    logic [15:0]               imm;
    logic [1:0]                sel1;
    logic [2:0]                sel2;
    logic [RAW-1:0]            rs_addr;
    logic [RAW-1:0]            rt_addr;
    logic [DATA_W-1:0]         rs_data;
    logic [DATA_W-1:0]         rt_data;
    logic [DATA_W-1:0]         cp_data;
    logic [NUM_FWD-1:0]        fwd_valid;
    logic [NUM_FWD-1:0]        fwd_ready;
    logic [NUM_FWD*RAW-1:0]    fwd_addr;
    logic [NUM_FWD*DATA_W-1:0] fwd_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         operand_1;
    logic [DATA_W-1:0]         operand_2;
    logic                      hazard;

    modport slave (
        input  in_valid, flush, pc, imm, sel1, sel2, rs_addr, rt_addr,
               rs_data, rt_data, cp_data, fwd_valid, fwd_ready, fwd_addr,
               fwd_data, out_ready,
        output in_ready, out_valid, operand_1, operand_2, hazard
    );

    modport master (
        output in_valid, flush, pc, imm, sel1, sel2, rs_addr, rt_addr,
               rs_data, rt_data, cp_data, fwd_valid, fwd_ready, fwd_addr,
               fwd_data, out_ready,
        input  in_ready, out_valid, operand_1, operand_2, hazard
    );
endinterface
`default_nettype wire

// File: rtl/operand_gen_pipe_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : operand_gen_pipe_fwd_mux
// Description : Per-source-register forwarding select; youngest matching
//               channel wins and reports whether its data is still pending.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_gen_pipe_fwd_mux #(
    parameter int NUM_FWD = 2,
    parameter int RAW     = 5,
    parameter int DATA_W  = 32
) (
    input  wire logic                      en,
    input  wire logic [RAW-1:0]            addr,
    input  wire logic [DATA_W-1:0]         rf_data,
    input  wire logic [NUM_FWD-1:0]        fwd_valid,
    input  wire logic [NUM_FWD-1:0]        fwd_ready,
    input  wire logic [NUM_FWD*RAW-1:0]    fwd_addr,
    input  wire logic [NUM_FWD*DATA_W-1:0] fwd_data,
    output logic      [DATA_W-1:0]         sel_data,
    output logic                           not_ready
);
    logic w_hit;
    logic w_nr;

    always_comb begin
        w_hit    = 1'b0;
        w_nr     = 1'b0;
        sel_data = rf_data;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (!w_hit && fwd_valid[i] && (fwd_addr[i*RAW +: RAW] == addr)) begin
                w_hit    = 1'b1;
                w_nr     = !fwd_ready[i];
                sel_data = fwd_data[i*DATA_W +: DATA_W];
            end
        end
        // r0 is hardwired: never forwarded, never stalls
        if (addr == '0) begin
            sel_data = '0;
            w_nr     = 1'b0;
        end
        not_ready = en && w_nr;
    end
endmodule
`default_nettype wire

// File: rtl/operand_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : operand_gen_pipe
// Description : Registered ID/EX operand generator with forwarding, load-use
//               stall and valid/ready output register.
//               Optional macro OPGEN_STALL_CNT_EN adds the stall_cycles port.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_gen_pipe
    import operand_gen_pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int RAW     = 5,
    parameter int NUM_FWD = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    operand_gen_pipe_if.slave  bus
`ifdef OPGEN_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);
    localparam int c_EXT_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int c_HI_W  = (DATA_W > 32) ? DATA_W : 32;

    logic [DATA_W-1:0]  w_rs_val;
    logic [DATA_W-1:0]  w_rt_val;
    logic               w_rs_nr;
    logic               w_rt_nr;
    logic               w_hazard;
    logic               w_in_ready;
    logic               w_xfer_in;
    logic [ADDR_W-1:0]  w_link;
    logic [c_EXT_W-1:0] w_link_ext;
    logic [c_HI_W-1:0]  w_hi_ext;
    logic [DATA_W-1:0]  w_op1;
    logic [DATA_W-1:0]  w_op2;
    logic               r_valid;
    logic [DATA_W-1:0]  r_op1;
    logic [DATA_W-1:0]  r_op2;

    operand_gen_pipe_fwd_mux #(.NUM_FWD(NUM_FWD), .RAW(RAW), .DATA_W(DATA_W)) u_fwd_rs (
        .en        (bus.sel1 == OPG_SRC1_REG),
        .addr      (bus.rs_addr),
        .rf_data   (bus.rs_data),
        .fwd_valid (bus.fwd_valid),
        .fwd_ready (bus.fwd_ready),
        .fwd_addr  (bus.fwd_addr),
        .fwd_data  (bus.fwd_data),
        .sel_data  (w_rs_val),
        .not_ready (w_rs_nr)
    );

    operand_gen_pipe_fwd_mux #(.NUM_FWD(NUM_FWD), .RAW(RAW), .DATA_W(DATA_W)) u_fwd_rt (
        .en        (bus.sel2 == OPG_SRC2_REG),
        .addr      (bus.rt_addr),
        .rf_data   (bus.rt_data),
        .fwd_valid (bus.fwd_valid),
        .fwd_ready (bus.fwd_ready),
        .fwd_addr  (bus.fwd_addr),
        .fwd_data  (bus.fwd_data),
        .sel_data  (w_rt_val),
        .not_ready (w_rt_nr)
    );

    assign w_hazard   = w_rs_nr || w_rt_nr;
    assign w_in_ready = !w_hazard && (!r_valid || bus.out_ready);
    assign w_xfer_in  = bus.in_valid && w_in_ready;

    // Link address wraps at ADDR_W, then is resized to the datapath
    assign w_link     = bus.pc + ADDR_W'(LINK_OFFSET);
    assign w_link_ext = c_EXT_W'(w_link);
    assign w_hi_ext   = c_HI_W'({bus.imm, 16'h0000});

    always_comb begin
        w_op1 = '0;
        case (opg_src1_e'(bus.sel1))
            OPG_SRC1_REG:  w_op1 = w_rs_val;
            OPG_SRC1_LINK: w_op1 = w_link_ext[DATA_W-1:0];
            OPG_SRC1_CP0:  w_op1 = bus.cp_data;
            default:       w_op1 = '0;
        endcase
    end

    always_comb begin
        w_op2 = '0;
        case (opg_src2_e'(bus.sel2))
            OPG_SRC2_REG:  w_op2 = w_rt_val;
            OPG_SRC2_SEXT: w_op2 = {{(DATA_W-16){bus.imm[15]}}, bus.imm};
            OPG_SRC2_ZEXT: w_op2 = DATA_W'(bus.imm);
            OPG_SRC2_HI:   w_op2 = w_hi_ext[DATA_W-1:0];
            default:       w_op2 = '0;
        endcase
    end

    // Flush outranks both transfers; operands are left stale on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_op1   <= '0;
            r_op2   <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_xfer_in) begin
            r_valid <= 1'b1;
            r_op1   <= w_op1;
            r_op2   <= w_op2;
        end else if (r_valid && bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.hazard    = w_hazard;
    assign bus.out_valid = r_valid;
    assign bus.operand_1 = r_op1;
    assign bus.operand_2 = r_op2;

`ifdef OPGEN_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (bus.in_valid && w_hazard && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

endmodule
`default_nettype wire
